// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution sequencer: FSM state
// encoding, the per-tap tag carried down the MAC pipeline, and the output count.
package conv_pkg;

    typedef enum logic [2:0] {
        LOAD,
        ISSUE,
        DRAIN,
        HOLD,
        DONE
    } state_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tap_t;

    // Number of output positions for a given stride; stride 0 behaves as 1.
    function automatic int n_outputs(input int x, input int f, input int s);
        int s_eff;
        s_eff = (s == 0) ? 1 : s;
        return (x - f) / s_eff + 1;
    endfunction

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// Valid/ready handshakes of the sequencer: x and filter load streams in,
// result stream out.
interface conv_seq_ctrl_if;

    logic s_valid_x;
    logic s_ready_x;
    logic s_valid_f;
    logic s_ready_f;
    logic m_valid_y;
    logic m_ready_y;

    modport master (
        output s_valid_x, s_valid_f, m_ready_y,
        input  s_ready_x, s_ready_f, m_valid_y
    );

    modport slave (
        input  s_valid_x, s_valid_f, m_ready_y,
        output s_ready_x, s_ready_f, m_valid_y
    );

endinterface

// File: rtl/conv_seq_ctrl_tap_delay_line.sv
// Fixed-depth shift of the {valid, first, last} tap tag, matching the latency
// from read-address issue to product valid at the accumulator.
module tap_delay_line
    import conv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  tap_t d,
    output tap_t q
);

    tap_t stage [DEPTH];

    // NOTE: sequential state uses <= so every stage samples its predecessor's
    // pre-edge value; blocking = here would collapse the pipe into one stage.
    // NOTE: this small pipe is reset (unlike a data RAM) so acc_en drops the
    // moment reset asserts instead of replaying stale taps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/conv_seq_ctrl.sv
// 1-D convolution sequencer: loads x/f memories, then walks every output
// position at the latched stride, driving read addresses, MAC enables and results.
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int X_MEM_SIZE = 8,
    parameter int F_MEM_SIZE = 4,
    parameter int X_ADDR_W   = $clog2(X_MEM_SIZE),
    parameter int F_ADDR_W   = $clog2(F_MEM_SIZE),
    parameter int MAC_LAT    = 2,
    parameter int STRIDE_W   = 2
) (
    input  logic                clk,
    input  logic                reset,
    conv_seq_ctrl_if.slave      hs,
    input  logic                conv_start,
    input  logic [STRIDE_W-1:0] stride,
    output logic                x_mem_wr_en,
    output logic [X_ADDR_W-1:0] x_wr_addr,
    output logic                f_mem_wr_en,
    output logic [F_ADDR_W-1:0] f_wr_addr,
    output logic [X_ADDR_W-1:0] x_rd_addr,
    output logic [F_ADDR_W-1:0] f_rd_addr,
    output logic                acc_clr,
    output logic                acc_en,
    output logic                conv_done,
    output logic                busy
);

    localparam int CW = X_ADDR_W + 1;
    localparam int FW = F_ADDR_W + 1;

    state_t              state, state_nx;
    logic [CW-1:0]       x_cnt, base, j, n_last;
    logic [FW-1:0]       f_cnt, k;
    logic [STRIDE_W-1:0] stride_eff;
    logic                start_q, start_pend;
    tap_t                tap_in, tap_out;

    logic start_rise, x_full_nx, f_full_nx, go, k_last, more;

    assign start_rise = conv_start & ~start_q;
    assign x_full_nx  = (x_cnt == CW'(X_MEM_SIZE)) |
                        (x_mem_wr_en & (x_cnt == CW'(X_MEM_SIZE - 1)));
    assign f_full_nx  = (f_cnt == FW'(F_MEM_SIZE)) |
                        (f_mem_wr_en & (f_cnt == FW'(F_MEM_SIZE - 1)));
    // A start edge coinciding with the final load write still launches next cycle.
    assign go         = x_full_nx & f_full_nx & (start_pend | start_rise);
    assign k_last     = (k == FW'(F_MEM_SIZE - 1));
    assign more       = (j < n_last);

    tap_delay_line #(.DEPTH(MAC_LAT)) u_taps (
        .clk   (clk),
        .reset (reset),
        .d     (tap_in),
        .q     (tap_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LOAD;
        else        state <= state_nx;
    end

    // NOTE: every output gets a default before the case so no path through
    // this block leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_nx     = state;
        hs.s_ready_x = 1'b0;
        hs.s_ready_f = 1'b0;
        hs.m_valid_y = 1'b0;
        x_mem_wr_en  = 1'b0;
        f_mem_wr_en  = 1'b0;
        x_wr_addr    = x_cnt[X_ADDR_W-1:0];
        f_wr_addr    = f_cnt[F_ADDR_W-1:0];
        x_rd_addr    = '0;
        f_rd_addr    = '0;
        tap_in       = '0;
        conv_done    = 1'b0;
        case (state)
            LOAD: begin
                hs.s_ready_x = (x_cnt < CW'(X_MEM_SIZE));
                hs.s_ready_f = (f_cnt < FW'(F_MEM_SIZE));
                x_mem_wr_en  = hs.s_valid_x & hs.s_ready_x;
                f_mem_wr_en  = hs.s_valid_f & hs.s_ready_f;
                if (go) state_nx = ISSUE;
            end
            ISSUE: begin
                x_rd_addr    = X_ADDR_W'(base + CW'(k));
                f_rd_addr    = k[F_ADDR_W-1:0];
                tap_in.valid = 1'b1;
                tap_in.first = (k == '0);
                tap_in.last  = k_last;
                if (k_last) state_nx = DRAIN;
            end
            DRAIN: begin
                if (tap_out.valid & tap_out.last) state_nx = HOLD;
            end
            HOLD: begin
                hs.m_valid_y = 1'b1;
                if (hs.m_ready_y) state_nx = more ? ISSUE : DONE;
            end
            DONE: begin
                conv_done = 1'b1;
                state_nx  = LOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

    assign acc_en  = tap_out.valid;
    assign acc_clr = tap_out.valid & tap_out.first;
    assign busy    = (state == ISSUE) | (state == DRAIN) | (state == HOLD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_cnt      <= '0;
            f_cnt      <= '0;
            base       <= '0;
            j          <= '0;
            k          <= '0;
            n_last     <= '0;
            stride_eff <= STRIDE_W'(1);
            start_q    <= 1'b0;
            start_pend <= 1'b0;
        end else begin
            start_q <= conv_start;
            if (x_mem_wr_en) x_cnt <= x_cnt + 1'b1;
            if (f_mem_wr_en) f_cnt <= f_cnt + 1'b1;
            if (start_rise && (state == LOAD || state == DONE)) begin
                start_pend <= 1'b1;
                stride_eff <= (stride == '0) ? STRIDE_W'(1) : stride;
                n_last     <= CW'(n_outputs(X_MEM_SIZE, F_MEM_SIZE, int'(stride)) - 1);
            end
            case (state)
                LOAD: if (go) begin
                    start_pend <= 1'b0;
                    base       <= '0;
                    j          <= '0;
                    k          <= '0;
                end
                ISSUE: k <= k_last ? '0 : k + 1'b1;
                HOLD: if (hs.m_ready_y && more) begin
                    j    <= j + 1'b1;
                    base <= base + CW'(stride_eff);
                end
                DONE: begin
                    x_cnt <= '0;
                    f_cnt <= '0;
                    j     <= '0;
                    base  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: table of stride runs checked cycle by cycle,
// plus hand-written sequences for backpressure, load/start overlap and reset.
module tb_conv_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       conv_start;
    logic [1:0] stride;
    logic       x_mem_wr_en, f_mem_wr_en, acc_clr, acc_en, conv_done, busy;
    logic [2:0] x_wr_addr, x_rd_addr;
    logic [1:0] f_wr_addr, f_rd_addr;

    always #5 clk = ~clk;

    conv_seq_ctrl_if hs ();

    conv_seq_ctrl #(
        .X_MEM_SIZE (8),
        .F_MEM_SIZE (4),
        .MAC_LAT    (2),
        .STRIDE_W   (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hs          (hs),
        .conv_start  (conv_start),
        .stride      (stride),
        .x_mem_wr_en (x_mem_wr_en),
        .x_wr_addr   (x_wr_addr),
        .f_mem_wr_en (f_mem_wr_en),
        .f_wr_addr   (f_wr_addr),
        .x_rd_addr   (x_rd_addr),
        .f_rd_addr   (f_rd_addr),
        .acc_clr     (acc_clr),
        .acc_en      (acc_en),
        .conv_done   (conv_done),
        .busy        (busy)
    );

    typedef struct {
        logic [1:0] stride;
        int         n_exp;
        int         step;
    } vec_t;

    vec_t vecs [4];
    int   n_checks = 0;
    int   n_errors = 0;
    int   lat;
    int   xc, fc;
    logic [2:0] hold_x;
    logic [1:0] hold_f;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fill 8 x words and 4 f words from empty with both valids held high.
    task automatic load_all();
        hs.s_valid_x = 1'b1;
        hs.s_valid_f = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("ld_x_wr", x_mem_wr_en, 1);
            check("ld_x_addr", x_wr_addr, i);
            check("ld_f_wr", f_mem_wr_en, i < 4);
            if (i < 4) check("ld_f_addr", f_wr_addr, i);
            else       check("ld_f_rdy_full", hs.s_ready_f, 0);
            step();
        end
        hs.s_valid_x = 1'b0;
        hs.s_valid_f = 1'b0;
        #1;
        check("ld_x_rdy_full", hs.s_ready_x, 0);
    endtask

    // Memories full: start edge now, ISSUE next cycle, then 7 cycles per output.
    task automatic run_conv(input logic [1:0] st, input int n_exp, input int stp);
        stride     = st;
        conv_start = 1'b1;
        step();
        conv_start = 1'b0;
        #1;
        for (int cyc = 0; cyc <= n_exp * 7; cyc++) begin
            int j = cyc / 7;
            int p = cyc % 7;
            check("run_acc_en", acc_en, (j < n_exp) && (p >= 2) && (p <= 5));
            check("run_acc_clr", acc_clr, (j < n_exp) && (p == 2));
            check("run_m_valid", hs.m_valid_y, (j < n_exp) && (p == 6));
            check("run_done", conv_done, cyc == n_exp * 7);
            if (j < n_exp && p < 4) begin
                check("run_x_rd", x_rd_addr, j * stp + p);
                check("run_f_rd", f_rd_addr, p);
                check("run_busy", busy, 1);
            end
            step();
            #1;
        end
        check("run_x_rdy_after", hs.s_ready_x, 1);
        check("run_f_rdy_after", hs.s_ready_f, 1);
    endtask

    task automatic wait_done(input string name);
        logic seen = 1'b0;
        hs.m_ready_y = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            #1;
            if (conv_done) seen = 1'b1;
            step();
        end
        check(name, seen, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{stride: 2'd1, n_exp: 5, step: 1};
        vecs[1] = '{stride: 2'd2, n_exp: 3, step: 2};
        vecs[2] = '{stride: 2'd3, n_exp: 2, step: 3};
        vecs[3] = '{stride: 2'd0, n_exp: 5, step: 1};

        reset        = 1'b0;
        conv_start   = 1'b0;
        stride       = 2'd0;
        hs.s_valid_x = 1'b0;
        hs.s_valid_f = 1'b0;
        hs.m_ready_y = 1'b1;
        #2;
        check("rst_s_ready_x", hs.s_ready_x, 1);
        check("rst_s_ready_f", hs.s_ready_f, 1);
        check("rst_x_wr_en", x_mem_wr_en, 0);
        check("rst_acc_en", acc_en, 0);
        check("rst_m_valid", hs.m_valid_y, 0);
        check("rst_done", conv_done, 0);
        check("rst_busy", busy, 0);
        check("rst_x_rd", x_rd_addr, 0);
        step();
        step();
        reset = 1'b1;

        for (int v = 0; v < 4; v++) begin
            load_all();
            run_conv(vecs[v].stride, vecs[v].n_exp, vecs[v].step);
        end

        // Backpressure in HOLD.
        load_all();
        hs.m_ready_y = 1'b0;
        stride       = 2'd1;
        conv_start   = 1'b1;
        step();
        conv_start = 1'b0;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (hs.m_valid_y) begin
                lat = i;
                break;
            end
            step();
        end
        check("bp_latency", lat, 6);
        hold_x = x_rd_addr;
        hold_f = f_rd_addr;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_m_valid", hs.m_valid_y, 1);
            check("bp_acc_en", acc_en, 0);
            check("bp_x_rd", x_rd_addr, hold_x);
            check("bp_f_rd", f_rd_addr, hold_f);
        end
        hs.m_ready_y = 1'b1;
        step();
        check("bp_next_issue", busy, 1);
        check("bp_next_x_rd", x_rd_addr, 1);
        check("bp_next_valid", hs.m_valid_y, 0);
        wait_done("bp_done");

        // Start pulsed after 3 of 8 x writes.
        stride       = 2'd2;
        hs.s_valid_x = 1'b1;
        hs.s_valid_f = 1'b1;
        for (int i = 0; i < 8; i++) begin
            conv_start = (i == 3);
            #1;
            check("ml_busy_load", busy, 0);
            step();
        end
        hs.s_valid_x = 1'b0;
        hs.s_valid_f = 1'b0;
        conv_start   = 1'b0;
        #1;
        check("ml_issue", busy, 1);
        check("ml_x_rd", x_rd_addr, 0);
        check("ml_f_rd", f_rd_addr, 0);
        wait_done("ml_done");

        // Sparse interleaved loads; start edge on the final x write.
        stride = 2'd3;
        xc = 0;
        fc = 0;
        for (int i = 0; i < 40 && xc < 8; i++) begin
            logic vx = (i % 2 == 0);
            logic vf = (i % 3 == 0);
            hs.s_valid_x = vx;
            hs.s_valid_f = vf;
            conv_start   = vx && (xc == 7);
            #1;
            check("sp_x_rdy", hs.s_ready_x, xc < 8);
            check("sp_x_wr", x_mem_wr_en, vx && (xc < 8));
            if (vx && xc < 8) check("sp_x_addr", x_wr_addr, xc);
            check("sp_f_rdy", hs.s_ready_f, fc < 4);
            check("sp_f_wr", f_mem_wr_en, vf && (fc < 4));
            if (vf && fc < 4) check("sp_f_addr", f_wr_addr, fc);
            if (vx && xc < 8) xc++;
            if (vf && fc < 4) fc++;
            step();
        end
        hs.s_valid_x = 1'b0;
        hs.s_valid_f = 1'b0;
        conv_start   = 1'b0;
        #1;
        check("sp_loaded", xc, 8);
        check("sp_issue", busy, 1);
        check("sp_x_rd", x_rd_addr, 0);
        wait_done("sp_done");

        // Reset asserted during DRAIN.
        load_all();
        stride     = 2'd1;
        conv_start = 1'b1;
        step();
        conv_start = 1'b0;
        repeat (4) step();
        #1;
        check("rd_pre_acc_en", acc_en, 1);
        #1;
        reset = 1'b0;
        #1;
        check("rd_acc_en", acc_en, 0);
        check("rd_m_valid", hs.m_valid_y, 0);
        check("rd_busy", busy, 0);
        step();
        step();
        reset = 1'b1;
        #1;
        check("rd_s_ready_x", hs.s_ready_x, 1);
        check("rd_s_ready_f", hs.s_ready_f, 1);
        check("rd_x_wr_addr", x_wr_addr, 0);

        // A pending start is discarded by reset.
        conv_start = 1'b1;
        step();
        conv_start = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        load_all();
        for (int i = 0; i < 5; i++) begin
            step();
            check("pend_lost_busy", busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
